// File: rtl/gfx_pkg.sv
// Shared types and helpers for the test-pattern pixel source:
// FSM state encoding and the RGB channel packing function.
package gfx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DRAW      = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } gfx_state_t;

    localparam int unsigned MAX_COLOR_BITS = 16;
    localparam int unsigned PACK_BITS      = 3 * MAX_COLOR_BITS;
    localparam int unsigned COLOR_SHIFT    = 4;
    localparam int unsigned FRAME_CNT_BITS = 8;

    typedef logic [MAX_COLOR_BITS-1:0] chan_t;
    typedef logic [PACK_BITS-1:0]      packed_color_t;

    // Packs {red, grn, blu}, each truncated to color_bits, into the low
    // 3*color_bits bits of the result; callers cast down to their pixel width.
    function automatic packed_color_t pack_color(
        input chan_t       red,
        input chan_t       grn,
        input chan_t       blu,
        input int unsigned color_bits
    );
        packed_color_t mask;
        mask = (packed_color_t'(1) << color_bits) - packed_color_t'(1);
        return ((packed_color_t'(red) & mask) << (2 * color_bits))
             | ((packed_color_t'(grn) & mask) << color_bits)
             |  (packed_color_t'(blu) & mask);
    endfunction

endpackage

// File: rtl/gfx_test_pattern_if.sv
// Valid/ready pixel-write channel from the pattern source to the
// framebuffer writer.
interface gfx_test_pattern_if #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned PIXEL_BITS = 12
);
    logic                  pix_valid;
    logic                  pix_ready;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic [PIXEL_BITS-1:0] pix_color;
    logic                  pix_last;

    modport master (
        output pix_valid,
        output pix_addr,
        output pix_color,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_addr,
        input  pix_color,
        input  pix_last,
        output pix_ready
    );
endinterface

// File: rtl/gfx_raster_cnt.sv
// Raster position counters: x/y plus a running linear address, so the
// address never needs a y*H_VISIBLE multiply.
module gfx_raster_cnt #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic                  i_inc,
    output logic [XW-1:0]         o_x_nxt,
    output logic [YW-1:0]         o_y_nxt,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    localparam logic [XW-1:0]         X_MAX    = XW'(H_VISIBLE - 1);
    localparam logic [YW-1:0]         Y_MAX    = YW'(V_VISIBLE - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(H_VISIBLE * V_VISIBLE - 1);

    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_last;

    logic [XW-1:0]         w_x_nxt;
    logic [YW-1:0]         w_y_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_last_nxt;

    // NOTE: every variable gets its hold value first so no path through the
    // block leaves it unassigned; that is what keeps this block latch-free.
    always_comb begin
        w_x_nxt    = r_x;
        w_y_nxt    = r_y;
        w_addr_nxt = r_addr;
        if (i_clear) begin
            w_x_nxt    = '0;
            w_y_nxt    = '0;
            w_addr_nxt = '0;
        end else if (i_inc) begin
            if (r_x == X_MAX) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == Y_MAX) ? '0 : r_y + YW'(1);
            end else begin
                w_x_nxt = r_x + XW'(1);
            end
            w_addr_nxt = (r_addr == ADDR_MAX) ? '0 : r_addr + ADDR_WIDTH'(1);
        end
        w_last_nxt = (w_x_nxt == X_MAX) && (w_y_nxt == Y_MAX);
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
            r_last <= 1'b0;
        end else begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_addr <= w_addr_nxt;
            r_last <= w_last_nxt;
        end
    end

    assign o_x_nxt = w_x_nxt;
    assign o_y_nxt = w_y_nxt;
    assign o_addr  = r_addr;
    assign o_last  = r_last;

endmodule

// File: rtl/gfx_test_pattern.sv
// Frame-based test-pattern source: draws one frame into the back buffer,
// then waits for the display-side swap before drawing the next.
module gfx_test_pattern
    import gfx_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned PIXEL_BITS = 12,
    parameter int unsigned ADDR_WIDTH = 20
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      swap_ack,
    gfx_test_pattern_if.master        pix,
    output logic                      frame_done,
    output logic [FRAME_CNT_BITS-1:0] frame_cnt
);

    localparam int unsigned COLOR_BITS = PIXEL_BITS / 3;
    localparam int unsigned XW = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
    localparam int unsigned YW = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;

    typedef logic [PIXEL_BITS-1:0] pixel_t;

    gfx_state_t r_state;
    gfx_state_t w_state_nxt;

    logic w_xfer;
    logic w_cnt_clear;
    logic w_cnt_inc;
    logic w_valid_nxt;
    logic w_done_nxt;
    logic w_fcnt_inc;

    logic [XW-1:0]             w_x_nxt;
    logic [YW-1:0]             w_y_nxt;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic                      w_last;
    logic [FRAME_CNT_BITS-1:0] w_frame_cnt_nxt;

    logic                      r_valid;
    logic                      r_frame_done;
    logic [FRAME_CNT_BITS-1:0] r_frame_cnt;
    pixel_t                    r_color;

    assign w_xfer = r_valid & pix.pix_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = 1'b0;
        w_cnt_clear = 1'b0;
        w_cnt_inc   = 1'b0;
        w_done_nxt  = 1'b0;
        w_fcnt_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_DRAW;
                    w_cnt_clear = 1'b1;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_DRAW: begin
                w_valid_nxt = 1'b1;
                if (w_xfer) begin
                    if (w_last) begin
                        w_state_nxt = ST_WAIT_SWAP;
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            ST_WAIT_SWAP: begin
                if (swap_ack) begin
                    w_fcnt_inc = 1'b1;
                    if (enable) begin
                        w_state_nxt = ST_DRAW;
                        w_cnt_clear = 1'b1;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The first pixel after a swap must already carry the incremented count.
    assign w_frame_cnt_nxt = w_fcnt_inc ? r_frame_cnt + FRAME_CNT_BITS'(1) : r_frame_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
            r_color      <= '0;
        end else begin
            r_valid      <= w_valid_nxt;
            r_frame_done <= w_done_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            if (w_cnt_clear || w_cnt_inc) begin
                r_color <= pixel_t'(pack_color(
                    chan_t'(32'(w_x_nxt) >> COLOR_SHIFT),
                    chan_t'(32'(w_y_nxt) >> COLOR_SHIFT),
                    chan_t'(w_frame_cnt_nxt),
                    COLOR_BITS));
            end
        end
    end

    gfx_raster_cnt #(
        .H_VISIBLE  (H_VISIBLE),
        .V_VISIBLE  (V_VISIBLE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .XW         (XW),
        .YW         (YW)
    ) u_raster_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_cnt_clear),
        .i_inc   (w_cnt_inc),
        .o_x_nxt (w_x_nxt),
        .o_y_nxt (w_y_nxt),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    assign pix.pix_valid = r_valid;
    assign pix.pix_addr  = w_addr;
    assign pix.pix_color = r_color;
    assign pix.pix_last  = w_last;
    assign frame_done    = r_frame_done;
    assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_gfx_test_pattern.sv
// Self-checking bench for gfx_test_pattern: a 4x3 instance for the frame,
// backpressure, swap and reset cases, and a 640x480 instance for colour/address.
module tb_gfx_test_pattern;

    localparam int SH = 4;
    localparam int SV = 3;
    localparam int SN = SH * SV;
    localparam int AW = 20;
    localparam int PB = 12;
    localparam int BH = 640;
    localparam int BV = 480;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_enable, s_swap_ack, s_done;
    logic [7:0] s_fcnt;
    logic       b_enable, b_swap_ack, b_done;
    logic [7:0] b_fcnt;

    gfx_test_pattern_if #(.ADDR_WIDTH(AW), .PIXEL_BITS(PB)) s_if ();
    gfx_test_pattern_if #(.ADDR_WIDTH(AW), .PIXEL_BITS(PB)) b_if ();

    always #5 clk = ~clk;

    gfx_test_pattern #(.H_VISIBLE(SH), .V_VISIBLE(SV), .PIXEL_BITS(PB), .ADDR_WIDTH(AW)) u_small (
        .clk(clk), .reset_n(reset_n), .enable(s_enable), .swap_ack(s_swap_ack),
        .pix(s_if.master), .frame_done(s_done), .frame_cnt(s_fcnt));

    gfx_test_pattern #(.H_VISIBLE(BH), .V_VISIBLE(BV), .PIXEL_BITS(PB), .ADDR_WIDTH(AW)) u_big (
        .clk(clk), .reset_n(reset_n), .enable(b_enable), .swap_ack(b_swap_ack),
        .pix(b_if.master), .frame_done(b_done), .frame_cnt(b_fcnt));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference colour from the pixel index: x/y by div/mod, channels 4 bits.
    function automatic logic [11:0] model_color(input int k, input int h, input int fc);
        int x;
        int y;
        x = k % h;
        y = k / h;
        return {4'((x >> 4) & 15), 4'((y >> 4) & 15), 4'(fc & 15)};
    endfunction

    typedef struct {
        logic        en;
        logic        rdy;
        logic        ack;
        logic        exp_valid;
        int          exp_addr;
        logic [11:0] exp_color;
        logic        exp_last;
        logic        exp_done;
        logic [7:0]  exp_fcnt;
    } vec_t;

    function automatic vec_t mk_vec(input logic en, input logic rdy, input logic ack,
                                    input logic vld, input int addr, input logic last,
                                    input logic done, input logic [7:0] fc);
        vec_t v;
        v.en        = en;
        v.rdy       = rdy;
        v.ack       = ack;
        v.exp_valid = vld;
        v.exp_addr  = addr;
        v.exp_color = model_color(addr, SH, int'(fc));
        v.exp_last  = last;
        v.exp_done  = done;
        v.exp_fcnt  = fc;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_small_zero(input string tag);
        check({tag, "_valid"}, 32'(s_if.pix_valid), 32'(0));
        check({tag, "_addr"},  32'(s_if.pix_addr),  32'(0));
        check({tag, "_color"}, 32'(s_if.pix_color), 32'(0));
        check({tag, "_last"},  32'(s_if.pix_last),  32'(0));
        check({tag, "_done"},  32'(s_done),         32'(0));
        check({tag, "_fcnt"},  32'(s_fcnt),         32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        int   k;
        int   n_xfer;
        int   cycles;
        logic finished;
        logic stalled;
        logic rdy;
        logic [AW-1:0] prev_addr;
        logic [PB-1:0] prev_color;

        // First frame at full throughput; the last vector also raises
        // swap_ack on the final transfer, which must be ignored.
        vecs[0] = mk_vec(1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i < SN; i++)
            vecs[i] = mk_vec(1'b1, 1'b1, 1'b0, 1'b1, i, (i == SN - 1), 1'b0, 8'd0);
        vecs[12] = mk_vec(1'b1, 1'b1, 1'b1, 1'b0, SN - 1, 1'b1, 1'b1, 8'd0);
        vecs[13] = mk_vec(1'b1, 1'b1, 1'b0, 1'b0, SN - 1, 1'b1, 1'b0, 8'd0);

        reset_n         = 1'b0;
        s_enable        = 1'b0;
        s_swap_ack      = 1'b0;
        s_if.pix_ready  = 1'b0;
        b_enable        = 1'b0;
        b_swap_ack      = 1'b0;
        b_if.pix_ready  = 1'b0;
        #22;
        check_small_zero("reset");
        check("reset_big_valid", 32'(b_if.pix_valid), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            s_enable       = vecs[i].en;
            s_if.pix_ready = vecs[i].rdy;
            s_swap_ack     = vecs[i].ack;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(s_if.pix_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_addr", i),  32'(s_if.pix_addr),  32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_color", i), 32'(s_if.pix_color), 32'(vecs[i].exp_color));
            check($sformatf("vec%0d_last", i),  32'(s_if.pix_last),  32'(vecs[i].exp_last));
            check($sformatf("vec%0d_done", i),  32'(s_done),         32'(vecs[i].exp_done));
            check($sformatf("vec%0d_fcnt", i),  32'(s_fcnt),         32'(vecs[i].exp_fcnt));
        end
        s_swap_ack = 1'b0;

        // Parked in WAIT_SWAP with no acknowledge.
        for (int i = 0; i < 50; i++) begin
            tick();
            check("wait_valid", 32'(s_if.pix_valid), 32'(0));
        end
        check("wait_fcnt", 32'(s_fcnt), 32'(0));

        s_enable   = 1'b1;
        s_swap_ack = 1'b1;
        tick();
        s_swap_ack = 1'b0;
        check("swap_fcnt",  32'(s_fcnt),         32'(1));
        check("swap_valid", 32'(s_if.pix_valid), 32'(1));
        check("swap_addr",  32'(s_if.pix_addr),  32'(0));
        check("swap_color", 32'(s_if.pix_color), 32'(model_color(0, SH, 1)));

        // Random backpressure; enable dropped and swap_ack pulsed mid-frame.
        k          = 0;
        n_xfer     = 0;
        finished   = 1'b0;
        stalled    = 1'b0;
        prev_addr  = '0;
        prev_color = '0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            check("bp_valid", 32'(s_if.pix_valid), 32'(1));
            check("bp_addr",  32'(s_if.pix_addr),  32'(k));
            check("bp_color", 32'(s_if.pix_color), 32'(model_color(k, SH, 1)));
            check("bp_last",  32'(s_if.pix_last),  32'(k == SN - 1));
            if (stalled) begin
                check("bp_hold_addr",  32'(s_if.pix_addr),  32'(prev_addr));
                check("bp_hold_color", 32'(s_if.pix_color), 32'(prev_color));
            end
            prev_addr      = s_if.pix_addr;
            prev_color     = s_if.pix_color;
            rdy            = 1'($urandom_range(0, 1));
            s_if.pix_ready = rdy;
            s_swap_ack     = (k == 5);
            s_enable       = 1'b0;
            tick();
            stalled = !rdy;
            if (rdy) begin
                n_xfer++;
                if (k == SN - 1) finished = 1'b1;
                else             k++;
            end
        end
        s_swap_ack = 1'b0;
        check("bp_finished", 32'(finished),        32'(1));
        check("bp_xfers",    32'(n_xfer),          32'(SN));
        check("bp_done",     32'(s_done),          32'(1));
        check("bp_end_vld",  32'(s_if.pix_valid),  32'(0));
        check("bp_fcnt",     32'(s_fcnt),          32'(1));
        tick();
        check("bp_done_pulse", 32'(s_done), 32'(0));

        // Swap with enable low: count advances, back to IDLE.
        s_swap_ack = 1'b1;
        tick();
        s_swap_ack = 1'b0;
        check("idle_fcnt", 32'(s_fcnt), 32'(2));
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_valid", 32'(s_if.pix_valid), 32'(0));
        end

        // Asynchronous reset in the middle of a frame.
        s_if.pix_ready = 1'b1;
        s_enable       = 1'b1;
        tick();
        s_enable = 1'b0;
        check("f3_color0", 32'(s_if.pix_color), 32'(model_color(0, SH, 2)));
        cycles = 0;
        while (s_if.pix_addr != AW'(7) && cycles < 20) begin
            tick();
            cycles++;
        end
        check("f3_reach7", 32'(s_if.pix_addr), 32'(7));
        reset_n = 1'b0;
        #2;
        check_small_zero("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(s_if.pix_valid), 32'(0));
        s_enable = 1'b1;
        tick();
        s_enable = 1'b0;
        check("restart_valid", 32'(s_if.pix_valid), 32'(1));
        check("restart_addr",  32'(s_if.pix_addr),  32'(0));
        check("restart_fcnt",  32'(s_fcnt),         32'(0));
        check("restart_color", 32'(s_if.pix_color), 32'(0));
        for (int i = 0; i < SN; i++) tick();
        check("restart_done", 32'(s_done), 32'(1));

        // Default geometry: address tracks cycles at full rate; colour at (32,48).
        b_if.pix_ready = 1'b1;
        b_enable       = 1'b1;
        tick();
        b_enable = 1'b0;
        cycles   = 0;
        while (b_if.pix_addr != AW'(30752) && cycles < 31000) begin
            tick();
            cycles++;
        end
        check("big_addr",   32'(b_if.pix_addr),  32'(48 * BH + 32));
        check("big_cycles", 32'(cycles),         32'(30752));
        check("big_valid",  32'(b_if.pix_valid), 32'(1));
        check("big_color",  32'(b_if.pix_color), 32'(12'h230));
        check("big_model",  32'(b_if.pix_color), 32'(model_color(30752, BH, 0)));
        check("big_last",   32'(b_if.pix_last),  32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
